// File: rtl/iiitb_seg_scan_pkg.sv
// Shared types and active-high segment patterns for the two-digit scanner.
// Bit order is {a,b,c,d,e,f,g}, so bit 6 is segment a.
package iiitb_seg_pkg;

  typedef enum logic [1:0] {
    UNITS = 2'd0,
    GAP_U = 2'd1,
    TENS  = 2'd2,
    GAP_T = 2'd3
  } state_e;

  localparam logic [6:0] SEG_0   = 7'b1111110;
  localparam logic [6:0] SEG_1   = 7'b0110000;
  localparam logic [6:0] SEG_2   = 7'b1101101;
  localparam logic [6:0] SEG_3   = 7'b1111001;
  localparam logic [6:0] SEG_4   = 7'b0110011;
  localparam logic [6:0] SEG_5   = 7'b1011011;
  localparam logic [6:0] SEG_6   = 7'b1011111;
  localparam logic [6:0] SEG_7   = 7'b1110000;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1111011;
  localparam logic [6:0] SEG_E   = 7'b1001111;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

endpackage

// File: rtl/iiitb_seg_scan_if.sv
// Digit capture inputs and display outputs of the scanner, bundled as one bus.
// The master side feeds digits in; the slave side drives the board display.
interface iiitb_seg_scan_if;

  logic [3:0] QZ;
  logic [3:0] QU;
  logic       LOAD;
  logic [6:0] SEG;
  logic [1:0] AN;
  logic       FRAME;
  logic       ERR;

  modport master (
    output QZ, QU, LOAD,
    input  SEG, AN, FRAME, ERR
  );

  modport slave (
    input  QZ, QU, LOAD,
    output SEG, AN, FRAME, ERR
  );

endinterface

// File: rtl/iiitb_seg_scan_bcd7seg.sv
// Combinational BCD to 7-segment decoder producing active-high patterns.
// Codes 10..15 decode to "E" and raise the invalid flag.
module iiitb_bcd7seg
  import iiitb_seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o,
  output logic       invalid_o
);

  always_comb begin
    seg_o     = SEG_E;
    invalid_o = 1'b0;
    unique case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: begin
        seg_o     = SEG_E;
        invalid_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/iiitb_seg_scan.sv
// Two-digit multiplexed 7-segment scanner with blanking gaps and frame-aligned updates.
// All display outputs are registered; polarity is applied only at the output registers.
module iiitb_seg_scan
  import iiitb_seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 1000,
  parameter int GAP_CYCLES   = 2,
  parameter int COMMON_ANODE = 0,
  parameter int BLANK_LZ     = 1
) (
  input  logic             CK,
  input  logic             RN,
  iiitb_seg_scan_if.slave  bus
);

  localparam int MAX_LEN = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LEN);
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] LAST_GAP   = CNT_W'(GAP_CYCLES - 1);
  localparam logic INV = (COMMON_ANODE != 0);
  localparam logic BLZ = (BLANK_LZ != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       pend_q, pend_d;
  logic [7:0]       disp_q, disp_d;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       an_q, an_d;
  logic             frame_q, frame_d;
  logic             err_q, err_d;

  logic [3:0] digit;
  logic [6:0] pattern;
  logic       invalid;
  logic       lit_units;
  logic       lit_tens;

  iiitb_bcd7seg u_dec (
    .bcd_i     (digit),
    .seg_o     (pattern),
    .invalid_o (invalid)
  );

  // Slot sequencing; the display register only reloads when a frame wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    disp_d  = disp_q;
    pend_d  = bus.LOAD ? {bus.QZ, bus.QU} : pend_q;
    unique case (state_q)
      UNITS: if (cnt_q == LAST_DIGIT) begin
        state_d = GAP_U;
        cnt_d   = '0;
      end
      GAP_U: if (cnt_q == LAST_GAP) begin
        state_d = TENS;
        cnt_d   = '0;
      end
      TENS: if (cnt_q == LAST_DIGIT) begin
        state_d = GAP_T;
        cnt_d   = '0;
      end
      GAP_T: if (cnt_q == LAST_GAP) begin
        state_d = UNITS;
        cnt_d   = '0;
        disp_d  = pend_q;
      end
      default: begin
        state_d = UNITS;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    digit     = (state_q == TENS) ? disp_q[7:4] : disp_q[3:0];
    lit_units = (state_q == UNITS);
    lit_tens  = (state_q == TENS) && !(BLZ && (disp_q[7:4] == 4'd0));
    seg_d     = (lit_units || lit_tens) ? pattern : SEG_OFF;
    an_d      = {lit_tens, lit_units};
    frame_d   = (state_q == UNITS) && (cnt_q == '0);
    err_d     = err_q | ((lit_units || lit_tens) && invalid);
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= UNITS;
      cnt_q   <= '0;
      pend_q  <= '0;
      disp_q  <= '0;
      seg_q   <= SEG_OFF ^ {7{INV}};
      an_q    <= {2{INV}};
      frame_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      disp_q  <= disp_d;
      seg_q   <= seg_d ^ {7{INV}};
      an_q    <= an_d ^ {2{INV}};
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

  assign bus.SEG   = seg_q;
  assign bus.AN    = an_q;
  assign bus.FRAME = frame_q;
  assign bus.ERR   = err_q;

endmodule

// File: tb/tb_iiitb_seg_scan.sv
// Directed bench running three scanner configurations side by side against a
// frame-position reference model, with expected outputs queued per clock edge.
module tb_iiitb_seg_scan;

  localparam int R = 4;
  localparam int G = 1;
  localparam int F = 2 * (R + G);

  typedef struct {
    int         id;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame;
    logic       err;
  } exp_t;

  logic       CK;
  logic       RN;
  logic [3:0] qz;
  logic [3:0] qu;
  logic       load;

  int   testCount;
  int   failCount;
  int   k;
  logic [7:0] pendM;
  logic [7:0] dispM;
  logic       errM [3];
  exp_t       sb [$];

  logic [6:0] decTab [10];
  int         caCfg  [3];
  int         blzCfg [3];

  iiitb_seg_scan_if bus0 ();
  iiitb_seg_scan_if bus1 ();
  iiitb_seg_scan_if bus2 ();

  assign bus0.QZ = qz;  assign bus0.QU = qu;  assign bus0.LOAD = load;
  assign bus1.QZ = qz;  assign bus1.QU = qu;  assign bus1.LOAD = load;
  assign bus2.QZ = qz;  assign bus2.QU = qu;  assign bus2.LOAD = load;

  iiitb_seg_scan #(.REFRESH_DIV(R), .GAP_CYCLES(G), .COMMON_ANODE(0), .BLANK_LZ(0))
    dut0 (.CK(CK), .RN(RN), .bus(bus0.slave));
  iiitb_seg_scan #(.REFRESH_DIV(R), .GAP_CYCLES(G), .COMMON_ANODE(0), .BLANK_LZ(1))
    dut1 (.CK(CK), .RN(RN), .bus(bus1.slave));
  iiitb_seg_scan #(.REFRESH_DIV(R), .GAP_CYCLES(G), .COMMON_ANODE(1), .BLANK_LZ(0))
    dut2 (.CK(CK), .RN(RN), .bus(bus2.slave));

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task checkField(input string tag, input int id, input logic [6:0] obs, input logic [6:0] expv);
    testCount++;
    assert (obs === expv) else begin
      failCount++;
      $error("[TB] FAIL dut%0d %s at edge %0d: observed %b expected %b", id, tag, k, obs, expv);
    end
  endtask

  task checkOutput();
    exp_t       e;
    logic [6:0] oSeg;
    logic [1:0] oAn;
    logic       oFrame;
    logic       oErr;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.id)
        0:       begin oSeg = bus0.SEG; oAn = bus0.AN; oFrame = bus0.FRAME; oErr = bus0.ERR; end
        1:       begin oSeg = bus1.SEG; oAn = bus1.AN; oFrame = bus1.FRAME; oErr = bus1.ERR; end
        default: begin oSeg = bus2.SEG; oAn = bus2.AN; oFrame = bus2.FRAME; oErr = bus2.ERR; end
      endcase
      checkField("SEG",   e.id, oSeg,              e.seg);
      checkField("AN",    e.id, {5'b0, oAn},       {5'b0, e.an});
      checkField("FRAME", e.id, {6'b0, oFrame},    {6'b0, e.frame});
      checkField("ERR",   e.id, {6'b0, oErr},      {6'b0, e.err});
    end
  endtask

  // Expected output for a given position within the frame of the cycle before the edge.
  task pushExpected(input int c, input int pos);
    exp_t       e;
    logic       litU;
    logic       litT;
    logic [3:0] d;
    logic [6:0] pat;
    litU = (pos < R);
    litT = (pos >= R + G) && (pos < 2 * R + G);
    if (litT && blzCfg[c] != 0 && dispM[7:4] == 4'd0) litT = 1'b0;
    d   = litU ? dispM[3:0] : dispM[7:4];
    pat = (d > 4'd9) ? 7'b1001111 : decTab[d];
    if ((litU || litT) && d > 4'd9) errM[c] = 1'b1;
    e.id    = c;
    e.seg   = (litU || litT) ? pat : 7'b0000000;
    e.an    = {litT, litU};
    e.frame = (pos == 0);
    e.err   = errM[c];
    if (caCfg[c] != 0) begin
      e.seg = ~e.seg;
      e.an  = ~e.an;
    end
    sb.push_back(e);
  endtask

  task pushOff();
    exp_t e;
    for (int c = 0; c < 3; c++) begin
      e.id    = c;
      e.seg   = (caCfg[c] != 0) ? 7'b1111111 : 7'b0000000;
      e.an    = (caCfg[c] != 0) ? 2'b11 : 2'b00;
      e.frame = 1'b0;
      e.err   = 1'b0;
      sb.push_back(e);
    end
  endtask

  task applyStimulus(input logic ld, input logic [3:0] z, input logic [3:0] u);
    int pos;
    @(negedge CK);
    load = ld;
    qz   = z;
    qu   = u;
    k++;
    pos = (k - 1) % F;
    for (int c = 0; c < 3; c++) pushExpected(c, pos);
    if (k % F == 0) dispM = pendM;
    if (ld) pendM = {z, u};
    @(posedge CK);
    #1;
    checkOutput();
  endtask

  // Asserts reset between edges, checks the outputs drop at once, then releases.
  task doReset();
    #1;
    load = 1'b0;
    RN   = 1'b0;
    #1;
    pushOff();
    checkOutput();
    k     = 0;
    pendM = 8'h00;
    dispM = 8'h00;
    for (int c = 0; c < 3; c++) errM[c] = 1'b0;
    repeat (2) @(posedge CK);
    #2;
    pushOff();
    checkOutput();
    RN = 1'b1;
  endtask

  initial begin
    decTab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
               7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    caCfg  = '{0, 0, 1};
    blzCfg = '{0, 1, 0};
    testCount = 0;
    failCount = 0;
    k    = 0;
    load = 1'b0;
    qz   = 4'd0;
    qu   = 4'd0;
    RN   = 1'b1;
    #2;
    doReset();

    // Idle scan of 0/0 for two full frames.
    repeat (20) applyStimulus(1'b0, 4'd0, 4'd0);

    // Load 47 in the middle of the tens slot; it appears only next frame.
    repeat (6) applyStimulus(1'b0, 4'd0, 4'd0);
    applyStimulus(1'b1, 4'd4, 4'd7);
    repeat (12) applyStimulus(1'b0, 4'd0, 4'd0);

    // Load 12 on the frame-wrap edge; the old pending value wins for one frame.
    applyStimulus(1'b1, 4'd1, 4'd2);
    repeat (20) applyStimulus(1'b0, 4'd0, 4'd0);

    // Leading-zero case 05.
    applyStimulus(1'b1, 4'd0, 4'd5);
    repeat (19) applyStimulus(1'b0, 4'd0, 4'd0);

    // Invalid units digit, then valid data while ERR must stay set.
    applyStimulus(1'b1, 4'd1, 4'd12);
    repeat (10) applyStimulus(1'b0, 4'd0, 4'd0);
    applyStimulus(1'b1, 4'd3, 4'd4);
    repeat (15) applyStimulus(1'b0, 4'd0, 4'd0);

    // Reset during the tens slot, then the scan restarts from units with 0/0.
    doReset();
    repeat (12) applyStimulus(1'b0, 4'd0, 4'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/iiitb_seg_scan.md
Name: iiitb_seg_scan

Overview:
- Downstream display stage for the two-digit BCD counter.
- Captures the tens and units digits, then time-multiplexes them onto one shared 7-segment bus with per-digit anode enables.
- Inserts blanking gaps between digits to prevent ghosting.
- Updates the shown value only at frame boundaries so a digit pair is never torn.
- Drives the board display directly; all outputs are registered.

Parameters:
- REFRESH_DIV, 1000, clock cycles each digit is lit; must be >= 2.
- GAP_CYCLES, 2, clock cycles all digits are dark between digit slots; must be >= 1.
- COMMON_ANODE, 0, 1 inverts SEG and AN (active-low display); 0 is active-high.
- BLANK_LZ, 1, 1 blanks the tens digit when it is 0.

Ports:
- CK  input  1  clock; all state changes on its rising edge.
- RN  input  1  asynchronous active-low reset.
- QZ  input  4  tens BCD digit from the counter.
- QU  input  4  units BCD digit from the counter.
- LOAD  input  1  capture strobe; QZ/QU are sampled into the pending register when it is high.
- SEG  output  7  segments {a,b,c,d,e,f,g}; SEG[6]=a, SEG[0]=g.
- AN  output  2  digit enables; AN[0]=units, AN[1]=tens.
- FRAME  output  1  one-cycle pulse on the first cycle of each units slot.
- ERR  output  1  sticky flag: a non-BCD digit (>9) was displayed.

Behaviour:
- Polarity: "on" means logic 1 when COMMON_ANODE=0 and logic 0 when COMMON_ANODE=1. This applies to SEG and AN alike.
- Reset (RN low, asynchronous):
  - state=UNITS, slot counter=0, pending={0,0}, display={0,0}.
  - SEG all off, AN all off, FRAME=0, ERR=0.
  - Reset applies immediately at any point, including mid-slot or mid-gap.
- FSM states: UNITS -> GAP_U -> TENS -> GAP_T -> UNITS.
  - UNITS and TENS each last REFRESH_DIV cycles.
  - GAP_U and GAP_T each last GAP_CYCLES cycles.
  - Slot counter runs from 0 to length-1 and clears on every state change.
  - Frame length = 2*(REFRESH_DIV+GAP_CYCLES).
- Capture: LOAD=1 at a rising edge writes pending <= {QZ,QU}. Pending only changes on LOAD; with no LOAD it holds its value.
- Frame update:
  - On the GAP_T->UNITS transition edge, display <= pending.
  - If LOAD is high on that same edge, display takes the old pending value and the new value appears next frame.
  - Pending never feeds SEG directly.
- Output timing:
  - SEG, AN and FRAME are registered: the value seen in cycle n reflects state and display in cycle n-1. Latency is one cycle.
  - After reset release, the first edge drives units segments and AN[0] on.
  - The units slot that follows reset release also asserts FRAME for one cycle.
- Digit slots:
  - UNITS: AN[0] on, AN[1] off, SEG = decode(display units).
  - TENS: AN[1] on, AN[0] off, SEG = decode(display tens).
  - GAP states: both AN off, SEG all off.
- Leading-zero blanking: with BLANK_LZ=1 and display tens=0, the TENS slot keeps AN[1] off and SEG all off. Slot timing is unchanged.
- Decode (a..g, 1=lit before the polarity step):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - 10..15 show "E"=1001111 and set ERR on the same edge the E is driven. ERR stays set until reset.
- Widths: slot counter is $clog2(max(REFRESH_DIV,GAP_CYCLES)) bits. No arithmetic is performed on the digits.

Decomposition:
- Shared package iiitb_seg_pkg holds:
  - the state enum (UNITS, GAP_U, TENS, GAP_T);
  - the ten digit patterns, the E pattern and the SEG_OFF constant (all 7-bit, active-high).
- One combinational sub-module, iiitb_bcd7seg: 4-bit BCD in, 7-bit active-high pattern plus an invalid flag out.
- The scanner applies COMMON_ANODE inversion at the output register stage only.

Test Plan:
- Reset/idle (REFRESH_DIV=4, GAP_CYCLES=1, COMMON_ANODE=0, BLANK_LZ=0): release RN -> AN=01 with SEG=1111110 for 4 cycles, then AN=00 for 1 cycle, then AN=10 with SEG=1111110 for 4 cycles, then AN=00 for 1 cycle. FRAME pulses every 10 cycles. ERR=0.
- Frame-aligned update: LOAD with QZ=4, QU=7 mid-TENS -> current frame still shows 0/0. Next units slot shows SEG=1110000 and tens slot shows SEG=0110011.
- Collision: LOAD (QZ=1, QU=2) on the GAP_T->UNITS edge -> that frame shows the previous value. The following frame shows 1 and 2.
- Leading-zero blanking (BLANK_LZ=1): display 05 -> units slot shows SEG=1011011 with AN=01. Tens slot has AN=00 and SEG=0000000. Gap and frame period are unchanged.
- Invalid digit and polarity (COMMON_ANODE=1): QU=12 loaded -> units slot SEG=0110000 (inverted E) with AN=10 (AN[0] active-low). ERR rises on the same edge and stays 1 after valid data returns. RN pulse clears ERR.
- Mid-slot reset: assert RN low during TENS -> SEG and AN go inactive immediately, without waiting for an edge. After release the scan restarts at UNITS with display 0/0.
